// File: rtl/rf_op_sequencer.sv
// Four-state register-file operation sequencer.
// Reads two sources, executes one ALU op, writes the result back.
module rf_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [ADDR_W-1:0] Ra,
  output logic [ADDR_W-1:0] Rb,
  output logic [ADDR_W-1:0] Rw,
  output logic              WrEn,
  output logic [DATA_W-1:0] busW,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  state_t              r_state;
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_ra;
  logic [ADDR_W-1:0]   r_rb;
  logic [ADDR_W-1:0]   r_rw;
  logic                r_wren;
  logic [DATA_W-1:0]   r_busw;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic                r_ovf;

  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_dif;
  logic [3:0]          w_sh;
  logic [DATA_W-1:0]   w_res;
  logic                w_ovf;
  logic                w_wr;
  logic                w_arith;

  assign w_sum = busA + busB;
  assign w_dif = busA - busB;
  assign w_sh  = busB[3:0];

  // ALU: result, overflow and write/arith qualifiers for the latched op
  always_comb begin
    w_res   = r_result;
    w_ovf   = r_ovf;
    w_wr    = 1'b1;
    w_arith = 1'b0;
    case (r_op)
      4'd0: begin
        w_res   = w_sum;
        w_arith = 1'b1;
        w_ovf   = (busA[DATA_W-1] == busB[DATA_W-1]) &&
                  (w_sum[DATA_W-1] != busA[DATA_W-1]);
      end
      4'd1: begin
        w_res   = w_dif;
        w_arith = 1'b1;
        w_ovf   = (busA[DATA_W-1] != busB[DATA_W-1]) &&
                  (w_dif[DATA_W-1] != busA[DATA_W-1]);
      end
      4'd2: w_res = busA & busB;
      4'd3: w_res = busA | busB;
      4'd4: w_res = busA ^ busB;
      4'd5: w_res = busA << w_sh;
      4'd6: w_res = busA >> w_sh;
      4'd7: w_res = $signed(busA) >>> w_sh;
      4'd8: w_res = {{(DATA_W-1){1'b0}},
                     ($signed(busA) < $signed(busB))};
      4'd9: w_res = busA;
      default: w_wr = 1'b0;
    endcase
  end

  // Sequencer FSM with registered register-file and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rw     <= '0;
      r_wren   <= 1'b0;
      r_busw   <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_op    <= opcode;
            r_rd    <= rd;
            r_ra    <= rs;
            r_rb    <= rt;
            r_state <= READ;
          end
        end
        READ: r_state <= EXEC;
        EXEC: begin
          r_done <= 1'b1;
          if (w_wr) begin
            r_result <= w_res;
            r_busw   <= w_res;
            r_rw     <= r_rd;
            r_wren   <= 1'b1;
          end
          if (w_arith) r_ovf <= w_ovf;
          r_state <= WB;
        end
        WB: begin
          r_done  <= 1'b0;
          r_wren  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign Ra          = r_ra;
  assign Rb          = r_rb;
  assign Rw          = r_rw;
  assign WrEn        = r_wren;
  assign busW        = r_busw;
  assign done        = r_done;
  assign result      = r_result;
  assign ovf         = r_ovf;

endmodule
